imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program over a byte stream and writes it into instruction
//   memory while holding the processor in reset.
//
//   Frame format:
//     count N, then N words (2 bytes each, high byte first), then a checksum.
//   The checksum is the XOR of the 2N data bytes; the count byte is excluded.
//
//   Ports
//     clk        : single clock; all state updates on its rising edge
//     rst        : synchronous, active-high reset
//     in_valid   : byte-stream valid
//     in_data    : byte-stream data
//     in_ready   : loader accepts a byte this cycle
//     reload     : restart request, honoured only in DONE or ERR
//     imem_we    : instruction-memory write strobe (one cycle per word)
//     imem_addr  : instruction-memory write address (word index)
//     imem_wdata : instruction-memory write data
//     cpu_rst    : holds the processor in reset while high
//     load_done  : program loaded and checksum correct
//     load_err   : load aborted (zero/oversized count or bad checksum)
//
//   The word register is assembled as {high byte, low byte}, so DATA_W is
//   expected to be 16.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        hs;
  logic        n_bad;
  logic        last_word;
  logic [7:0]  n_reg;
  logic [7:0]  word_cnt;
  logic [7:0]  xor_acc;

  assign hs = in_valid && in_ready;

  // A count of zero, or more words than the address space holds, is rejected.
  assign n_bad = (in_data == 8'd0) || (32'(in_data) > (32'd1 << ADDR_W));

  // word_cnt counts words completed before the current LO byte.
  assign last_word = (word_cnt == (n_reg - 8'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    cpu_rst   = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (hs) state_nx = n_bad ? ERR : HI;
      end
      HI: begin
        in_ready = 1'b1;
        if (hs) state_nx = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (hs) state_nx = last_word ? CHK : HI;
      end
      CHK: begin
        in_ready = 1'b1;
        if (hs) state_nx = (in_data == xor_acc) ? DONE : ERR;
      end
      DONE: begin
        cpu_rst   = 1'b0;
        load_done = 1'b1;
        if (reload) state_nx = IDLE;
      end
      ERR: begin
        load_err = 1'b1;
        if (reload) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: count/word/XOR capture and the one-cycle write strobe.
  // Address and data only change on the edge that ends the strobe cycle,
  // so both are stable while imem_we is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg      <= 8'd0;
      word_cnt   <= 8'd0;
      xor_acc    <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
      case (state)
        IDLE: begin
          if (hs && !n_bad) begin
            n_reg     <= in_data;
            word_cnt  <= 8'd0;
            xor_acc   <= 8'd0;
            imem_addr <= '0;
          end
        end
        HI: begin
          if (hs) begin
            imem_wdata[15:8] <= in_data;
            xor_acc          <= xor_acc ^ in_data;
          end
        end
        LO: begin
          if (hs) begin
            imem_wdata[7:0] <= in_data;
            xor_acc         <= xor_acc ^ in_data;
            imem_we         <= 1'b1;
            word_cnt        <= word_cnt + 8'd1;
          end
        end
        DONE, ERR: begin
          if (reload) begin
            imem_addr <= '0;
            word_cnt  <= 8'd0;
            xor_acc   <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [15:0]       wr_data_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Memory write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    for (int i = 0; i < gap; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pick_gap(input int gmode, output int gap);
    if (gmode == 0)      gap = 0;
    else if (gmode == 1) gap = 1;
    else                 gap = $urandom_range(0, 3);
  endtask

  // Reference: a frame is accepted when 0 < N <= 2^ADDR_W and the trailing
  // byte equals the XOR of the data bytes. Word i lands at address i.
  task automatic run_frame(input logic [7:0] bytes[$], input int gmode, input string tag);
    int base, n, gap, nexp;
    logic [7:0] x;
    logic bad_n, exp_done;
    base  = wr_addr_q.size();
    n     = int'(bytes[0]);
    bad_n = (n == 0) || (n > (1 << ADDR_W));
    x = 8'h00;
    if (bad_n) begin
      send(bytes[0], 0);
    end else begin
      for (int i = 0; i < 2 * n + 2; i++) begin
        pick_gap(gmode, gap);
        send(bytes[i], gap);
        if (i >= 1 && i <= 2 * n) x = x ^ bytes[i];
      end
    end
    repeat (2) @(negedge clk);
    exp_done = !bad_n && (x == bytes[2 * n + 1]);
    nexp     = bad_n ? 0 : n;
    check({tag, "_done"},    32'(load_done), 32'(exp_done));
    check({tag, "_err"},     32'(load_err),  32'(!exp_done));
    check({tag, "_cpu_rst"}, 32'(cpu_rst),   32'(!exp_done));
    check({tag, "_ready"},   32'(in_ready),  32'd0);
    check({tag, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'(nexp));
    for (int i = 0; i < nexp && (base + i) < wr_addr_q.size(); i++) begin
      check({tag, "_waddr"}, 32'(wr_addr_q[base + i]), 32'(i));
      check({tag, "_wdata"}, 32'(wr_data_q[base + i]),
            {16'h0, bytes[1 + 2 * i], bytes[2 + 2 * i]});
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"},   32'(in_ready),  32'd1);
    check({tag, "_we"},      32'(imem_we),   32'd0);
    check({tag, "_addr"},    32'(imem_addr), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst),   32'd1);
    check({tag, "_done"},    32'(load_done), 32'd0);
    check({tag, "_err"},     32'(load_err),  32'd0);
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check_idle(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(tag);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
  endtask

  logic [7:0] fr[$];
  logic [7:0] x;
  int n, base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_wdata", 32'(imem_wdata), 32'd0);
    rst = 1'b0;

    // Good load, back to back.
    fr = '{8'h02, 8'h22, 8'h81, 8'h21, 8'h42, 8'hC0};
    run_frame(fr, 0, "good");
    check("good_addr_after", 32'(imem_addr), 32'd2);
    do_reload("reload1");

    // Bad checksum.
    fr = '{8'h02, 8'h22, 8'h81, 8'h21, 8'h42, 8'h00};
    run_frame(fr, 0, "badchk");
    do_reload("reload2");

    // Zero count: ERR right after the count byte, no write.
    base = wr_addr_q.size();
    send(8'h00, 0);
    check("zero_err",   32'(load_err), 32'd1);
    check("zero_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("zero_nwrites", 32'(wr_addr_q.size() - base), 32'd0);
    do_reload("reload3");

    // Good load with in_valid every other cycle.
    fr = '{8'h02, 8'h22, 8'h81, 8'h21, 8'h42, 8'hC0};
    run_frame(fr, 1, "gapped");
    do_reload("reload4");

    // Reset mid-frame, then a fresh good load.
    send(8'h02, 0); send(8'h22, 0); send(8'h81, 0);
    do_reset("midrst");
    run_frame(fr, 0, "after_rst");

    // Reload from DONE, a reload pulse mid-frame is ignored.
    do_reload("reload5");
    base = wr_addr_q.size();
    send(8'h01, 0); send(8'h00, 0);
    check("rl_cpu_rst_mid", 32'(cpu_rst), 32'd1);
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    check("rl_ignored_ready", 32'(in_ready), 32'd1);
    send(8'h00, 0);
    check("rl_cpu_rst_mid2", 32'(cpu_rst), 32'd1);
    send(8'h00, 0);
    repeat (2) @(negedge clk);
    check("rl_done",    32'(load_done), 32'd1);
    check("rl_cpu_rst", 32'(cpu_rst),   32'd0);
    check("rl_nwrites", 32'(wr_addr_q.size() - base), 32'd1);
    if (wr_data_q.size() > base) check("rl_wdata", 32'(wr_data_q[base]), 32'd0);
    do_reload("reload6");

    // Count boundary: 2^ADDR_W words is fine, one more is rejected.
    for (int k = 0; k < 2; k++) begin
      n = (1 << ADDR_W) + k;
      fr = {};
      fr.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        fr.push_back(8'($urandom));
        x = x ^ fr[fr.size() - 1];
      end
      fr.push_back(x);
      run_frame(fr, 0, k == 0 ? "n_max" : "n_over");
      do_reload("reload_b");
    end

    // Randomized frames with random gaps and random checksum corruption.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 9);
      fr = {};
      fr.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        fr.push_back(8'($urandom));
        x = x ^ fr[fr.size() - 1];
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      fr.push_back(x);
      run_frame(fr, 2, "rand");
      do_reload("reload_r");
    end

    // rst wins over reload and a pending byte in the same cycle.
    fr = '{8'h02, 8'h22, 8'h81, 8'h21, 8'h42, 8'hC0};
    run_frame(fr, 0, "pre_prio");
    @(negedge clk);
    rst = 1'b1; reload = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    @(posedge clk);
    #1;
    rst = 1'b0; reload = 1'b0; in_valid = 1'b0;
    check_idle("prio");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
